two_issue_fetch_buffer: RTL and testbench

Instruction pair buffer on the producer side of the dual-issue decoder. It accepts one fetched instruction per cycle and its PC from instruction memory, and holds them in order in a small circular queue. Each cycle it presents the two oldest entries as the candidate pair. The decode and issue logic pops one entry (single issue) or two entries (dual issue) per cycle. `flush_i` empties the buffer on redirects.

---
 rtl/two_issue_fetch_buffer_if.sv | 35 +++
 rtl/two_issue_fetch_buffer.sv | 81 ++++++++
 tb/tb_two_issue_fetch_buffer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/two_issue_fetch_buffer_if.sv
// Fetch-side and decode-side handshake bundle for the two-issue fetch buffer.
// The master is the fetch/decode logic; the slave is the buffer itself.
interface two_issue_fetch_buffer_if #(
    parameter int els_p      = 4,
    parameter int pc_width_p = 22
);
    localparam int cnt_w = $clog2(els_p + 1);

    logic                  v_i;
    logic [31:0]           instruction_i;
    logic [pc_width_p-1:0] pc_i;
    logic                  ready_o;
    logic                  flush_i;
    logic                  instr0_v_o;
    logic [31:0]           instr0_o;
    logic [pc_width_p-1:0] pc0_o;
    logic                  instr1_v_o;
    logic [31:0]           instr1_o;
    logic [pc_width_p-1:0] pc1_o;
    logic                  yumi_i;
    logic                  dual_i;
    logic [cnt_w-1:0]      count_o;

    modport master (
        output v_i, instruction_i, pc_i, flush_i, yumi_i, dual_i,
        input  ready_o, instr0_v_o, instr0_o, pc0_o,
        input  instr1_v_o, instr1_o, pc1_o, count_o
    );

    modport slave (
        input  v_i, instruction_i, pc_i, flush_i, yumi_i, dual_i,
        output ready_o, instr0_v_o, instr0_o, pc0_o,
        output instr1_v_o, instr1_o, pc1_o, count_o
    );
endinterface

// File: rtl/two_issue_fetch_buffer.sv
// Circular queue of fetched {instruction, pc} presenting the two oldest
// entries to a dual-issue decoder; pops 0, 1 or 2 entries per cycle.
module two_issue_fetch_buffer #(
    parameter int els_p      = 4,
    parameter int pc_width_p = 22
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    two_issue_fetch_buffer_if.slave fb
);
    localparam int ptr_w = $clog2(els_p);
    localparam int cnt_w = $clog2(els_p + 1);

    logic [31:0]           instr_mem [els_p];
    logic [pc_width_p-1:0] pc_mem    [els_p];

    logic [ptr_w-1:0] rptr_r;
    logic [ptr_w-1:0] wptr_r;
    logic [ptr_w-1:0] rptr1;
    logic [cnt_w-1:0] count_r;
    logic [cnt_w-1:0] count_n;
    logic [cnt_w-1:0] enq_amt;
    logic [cnt_w-1:0] pop_amt;
    logic             v0;
    logic             v1;
    logic             full;
    logic             enq;

    assign v0    = (count_r != '0);
    assign v1    = (count_r > cnt_w'(1));
    assign full  = (count_r == cnt_w'(els_p));
    assign rptr1 = rptr_r + ptr_w'(1);
    assign enq   = fb.v_i & ~full & ~fb.flush_i;

    always_comb begin
        pop_amt = '0;
        if (fb.yumi_i && v0) begin
            pop_amt = (fb.dual_i && v1) ? cnt_w'(2) : cnt_w'(1);
        end
        enq_amt = {{(cnt_w-1){1'b0}}, enq};
        count_n = count_r + enq_amt - pop_amt;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || fb.flush_i) begin
            rptr_r  <= '0;
            wptr_r  <= '0;
            count_r <= '0;
        end else begin
            rptr_r  <= rptr_r + ptr_w'(pop_amt);
            wptr_r  <= wptr_r + ptr_w'(enq);
            count_r <= count_n;
        end
    end

    // Storage is deliberately unreset; valids gate all visibility.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            instr_mem[wptr_r] <= fb.instruction_i;
            pc_mem[wptr_r]    <= fb.pc_i;
        end
    end

    assign fb.ready_o    = ~full;
    assign fb.count_o    = count_r;
    assign fb.instr0_v_o = v0;
    assign fb.instr1_v_o = v1;
    assign fb.instr0_o   = v0 ? instr_mem[rptr_r] : '0;
    assign fb.pc0_o      = v0 ? pc_mem[rptr_r]    : '0;
    assign fb.instr1_o   = v1 ? instr_mem[rptr1]  : '0;
    assign fb.pc1_o      = v1 ? pc_mem[rptr1]     : '0;

    always_ff @(posedge clk_i) begin
        if (!reset_i && !fb.flush_i) begin
            assert (!(fb.yumi_i && !v0))
                else $warning("yumi_i asserted while buffer empty");
            assert (!(fb.yumi_i && fb.dual_i && v0 && !v1))
                else $warning("dual_i asserted with only one entry held");
        end
    end
endmodule

// File: tb/tb_two_issue_fetch_buffer.sv
// Directed bench for two_issue_fetch_buffer with hand-computed expectations.
// Inputs change #1 after posedge; outputs are sampled there too.
module tb_two_issue_fetch_buffer;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    two_issue_fetch_buffer_if #(.els_p(4), .pc_width_p(22)) fb ();

    two_issue_fetch_buffer #(.els_p(4), .pc_width_p(22)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .fb      (fb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ins(input logic [21:0] pc);
        return 32'hC0DE_0000 | {10'd0, pc};
    endfunction

    task automatic cyc(input logic v, input logic [21:0] pc,
                       input logic yumi, input logic dual, input logic fl);
        fb.v_i           = v;
        fb.pc_i          = pc;
        fb.instruction_i = ins(pc);
        fb.yumi_i        = yumi;
        fb.dual_i        = dual;
        fb.flush_i       = fl;
        @(posedge clk);
        #1;
        fb.v_i     = 1'b0;
        fb.yumi_i  = 1'b0;
        fb.dual_i  = 1'b0;
        fb.flush_i = 1'b0;
    endtask

    task automatic push(input logic [21:0] pc);
        cyc(1'b1, pc, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        fb.v_i = 1'b0;
        fb.pc_i = '0;
        fb.instruction_i = '0;
        fb.yumi_i = 1'b0;
        fb.dual_i = 1'b0;
        fb.flush_i = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_ready", fb.ready_o, 1);
        check("rst_v0", fb.instr0_v_o, 0);
        check("rst_v1", fb.instr1_v_o, 0);
        check("rst_count", fb.count_o, 0);
        check("rst_instr0", fb.instr0_o, 0);
        check("rst_pc1", fb.pc1_o, 0);

        // A then B, no consumer
        push(22'h10);
        check("a_v0", fb.instr0_v_o, 1);
        check("a_v1", fb.instr1_v_o, 0);
        check("a_pc0", fb.pc0_o, 22'h10);
        check("a_instr1_zero", fb.instr1_o, 0);
        push(22'h14);
        check("b_v0", fb.instr0_v_o, 1);
        check("b_v1", fb.instr1_v_o, 1);
        check("b_pc0", fb.pc0_o, 22'h10);
        check("b_pc1", fb.pc1_o, 22'h14);
        check("b_count", fb.count_o, 2);
        check("b_instr1", fb.instr1_o, 32'hC0DE_0014);

        // Full boundary
        cyc(1'b0, 22'h0, 1'b0, 1'b0, 1'b1);
        check("fl0_count", fb.count_o, 0);
        for (int i = 0; i < 4; i++) push(22'(i * 4));
        check("full_count", fb.count_o, 4);
        check("full_ready", fb.ready_o, 0);
        cyc(1'b1, 22'h40, 1'b1, 1'b1, 1'b0);
        check("pop2_count", fb.count_o, 2);
        check("pop2_pc0", fb.pc0_o, 22'h8);
        check("pop2_pc1", fb.pc1_o, 22'hC);
        check("pop2_ready", fb.ready_o, 1);
        cyc(1'b0, 22'h0, 1'b1, 1'b1, 1'b0);
        check("held_not_taken", fb.count_o, 0);

        // Move pointers to 3 (both at 0 now)
        push(22'h50);
        push(22'h54);
        push(22'h58);
        cyc(1'b0, 22'h0, 1'b1, 1'b1, 1'b0);
        check("sp_pc0", fb.pc0_o, 22'h58);
        cyc(1'b0, 22'h0, 1'b1, 1'b0, 1'b0);
        check("sp_count", fb.count_o, 0);
        push(22'h20);
        push(22'h24);
        check("wrap_pc0", fb.pc0_o, 22'h20);
        check("wrap_pc1", fb.pc1_o, 22'h24);
        check("wrap_instr1", fb.instr1_o, 32'hC0DE_0024);
        cyc(1'b0, 22'h0, 1'b1, 1'b1, 1'b0);
        check("wrap_count", fb.count_o, 0);
        push(22'h28);
        check("wrap_next_pc0", fb.pc0_o, 22'h28);
        check("wrap_next_count", fb.count_o, 1);

        // Dual with single entry degrades to one pop
        cyc(1'b0, 22'h0, 1'b1, 1'b1, 1'b0);
        check("deg_count", fb.count_o, 0);
        check("deg_v0", fb.instr0_v_o, 0);
        cyc(1'b0, 22'h0, 1'b1, 1'b0, 1'b0);
        check("empty_yumi", fb.count_o, 0);

        // Enqueue with 2-pop from count 3
        push(22'h100);
        push(22'h104);
        push(22'h108);
        cyc(1'b1, 22'h30, 1'b1, 1'b1, 1'b0);
        check("ep_count", fb.count_o, 2);
        check("ep_pc0", fb.pc0_o, 22'h108);
        check("ep_pc1", fb.pc1_o, 22'h30);
        cyc(1'b1, 22'h200, 1'b1, 1'b0, 1'b0);
        check("steady_count", fb.count_o, 2);
        check("steady_pc0", fb.pc0_o, 22'h30);
        check("steady_pc1", fb.pc1_o, 22'h200);

        // Flush with concurrent enqueue and pop
        push(22'h204);
        check("pre_fl_count", fb.count_o, 3);
        cyc(1'b1, 22'h300, 1'b1, 1'b0, 1'b1);
        check("fl_count", fb.count_o, 0);
        check("fl_v0", fb.instr0_v_o, 0);
        check("fl_v1", fb.instr1_v_o, 0);
        check("fl_ready", fb.ready_o, 1);
        check("fl_pc0", fb.pc0_o, 0);
        push(22'h400);
        check("post_fl_pc0", fb.pc0_o, 22'h400);
        check("post_fl_count", fb.count_o, 1);
        check("post_fl_instr0", fb.instr0_o, 32'hC0DE_0400);

        // Reset mid-stream
        push(22'h404);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_count", fb.count_o, 0);
        check("mid_rst_v0", fb.instr0_v_o, 0);
        push(22'h500);
        check("after_rst_pc0", fb.pc0_o, 22'h500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
